csr_sequencer: RTL and testbench
================================

CSR_SEQUENCER -- requirements
Module: csr_sequencer

Interface
REQ-001 The block SHALL have a parameter MTVEC_ADDR, default 32'h4: trap vector used for redirects.
REQ-002 The block SHALL have these ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a SYSTEM-opcode instruction.
- instr  in  32  instruction word.
- pc  in  32  PC of the instruction.
- rs1_val  in  32  rs1 register value.
- exc_req  in  1  external exception request.
- exc_cause  in  5  cause code for exc_req.
- exc_addr  in  32  faulting address for exc_req.
- csr_rdata  in  32  CSR read data from the CSR file.
- csr_invalid  in  1  CSR file flags an unimplemented address.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- rd_we  out  1  register write enable.
- rd_addr  out  5  instr[11:7].
- rd_data  out  32  old CSR value.
- csr_addr  out  12  CSR address.
- csr_read  out  1  CSR read strobe.
- csr_write  out  1  CSR write strobe.
- csr_write_type  out  2  01 write, 10 set, 11 clear.
- csr_bus  out  32  write operand, or exception PC.
- csr_tval  out  32  trap value address.
- trap  out  1  trap strobe.
- trap_cause  out  5  trap cause code.
- ret  out  1  MRET strobe.
- redirect  out  1  new_pc is valid.
- new_pc  out  32  next fetch PC.

Function
REQ-003 The FSM SHALL have the states IDLE, DECODE, READ, WRITE, TRAP, RET and DONE.
REQ-004 In IDLE, exc_req SHALL take priority over start.
- Capture exc_cause, exc_addr and pc, then go to TRAP.
- Otherwise start captures instr, pc and rs1_val, then goes to DECODE.
REQ-005 start and exc_req SHALL be ignored whenever busy=1.
REQ-006 DECODE SHALL classify the captured instruction and pick the next state:
- opcode != 7'b1110011: TRAP, cause 2.
- funct3 001/010/011 (register forms), operand = rs1_val: READ.
- funct3 101/110/111 (immediate forms), operand = zero-extended instr[19:15]: READ.
- funct3 000 with instr[31:20]=0 (ECALL): TRAP, cause 11.
- funct3 000 with instr[31:20]=1 (EBREAK): TRAP, cause 3.
- funct3 000 with instr[31:20]=12'h302 (MRET): RET.
- Any other encoding, including funct3 100: TRAP, cause 2.
REQ-007 A write SHALL be required when funct3[1:0]=01, or when instr[19:15] != 0.
REQ-008 READ SHALL last one cycle with csr_read=1 and csr_addr=instr[31:20]; it then branches:
- csr_invalid=1: TRAP, cause 2.
- Write required and csr_addr[11:10]=2'b11 (read-only CSR): TRAP, cause 2.
- Otherwise latch csr_rdata into rd_data, then go to WRITE if a write is required, else DONE.
REQ-009 WRITE SHALL last one cycle, then go to DONE, and drive:
- csr_write=1.
- csr_write_type=funct3[1:0].
- csr_bus=operand.
- csr_addr unchanged.
REQ-010 TRAP SHALL last one cycle, then go to IDLE, and drive:
- trap=1 with the captured cause.
- csr_bus=captured pc.
- csr_tval=captured exc_addr for external exceptions, otherwise pc.
- redirect=1, new_pc=MTVEC_ADDR.
REQ-011 RET SHALL last one cycle, then go to IDLE, and drive:
- ret=1, csr_read=1, csr_addr=12'h341.
- redirect=1, new_pc={csr_rdata[31:2],2'b00}.
REQ-012 DONE SHALL last one cycle, then go to IDLE, and drive:
- done=1.
- rd_we=1 only if rd_addr != 0.
- redirect=1, new_pc=pc+4, modulo 2^32.
REQ-013 TRAP and RET SHALL not assert done or rd_we.
REQ-014 All strobes (csr_read, csr_write, trap, ret, redirect, done, rd_we) SHALL be low in every state not listed for them, so they are mutually consistent per cycle.
REQ-015 Latency from the start cycle SHALL be:
- CSR op with write: 4 cycles to done.
- CSR op without write: 3 cycles to done.
- Trap or MRET: 2 cycles to redirect.
- External exception: 1 cycle to trap.

Reset
REQ-016 When rst=1 at a clock edge, the block SHALL enter IDLE, abandoning any operation in progress with no strobe in the following cycle.
REQ-017 In IDLE after reset, all outputs SHALL be 0, including rd_data, csr_bus, csr_tval and new_pc.

Verification
REQ-018 CSRRW, rs1=x5 with rs1_val=32'hDEADBEEF, rd=x3, csr 12'h340, pc=32'h100, csr_rdata=32'h12:
- cycle 2: csr_read.
- cycle 3: csr_write with type 01, bus=DEADBEEF.
- cycle 4: done, rd_we, rd_data=32'h12, new_pc=32'h104.
REQ-019 CSRRS with rs1=x0 on csr 12'hF14: no csr_write; done in cycle 3 with rd_data=0.
REQ-020 CSRRWI on csr 12'hF11: trap with cause 2 in cycle 3, new_pc=32'h4, csr_bus=pc, and no csr_write.
REQ-021 ECALL at pc=32'h200: trap with cause 11 in cycle 2, csr_bus=32'h200. MRET with csr_rdata=32'h203: ret with new_pc=32'h200.
REQ-022 exc_req in IDLE with cause 4 and exc_addr=32'h1001, together with start: trap in cycle 1 with cause 4 and csr_tval=32'h1001; start is ignored.
REQ-023 rst asserted in WRITE: the next cycle is IDLE with every output 0; a following start runs normally.

Source files
------------

// File: rtl/csr_sequencer.sv
// Sequencer for RISC-V SYSTEM-opcode instructions: Zicsr read/modify/write, ECALL/EBREAK/MRET,
// and external exception entry. Outputs are decoded from state, so IDLE drives all zeros.
module csr_sequencer #(
   parameter logic [31:0] MTVEC_ADDR = 32'h4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [31:0] instr,
   input  logic [31:0] pc,
   input  logic [31:0] rs1_val,
   input  logic        exc_req,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_addr,
   input  logic [31:0] csr_rdata,
   input  logic        csr_invalid,
   output logic        busy,
   output logic        done,
   output logic        rd_we,
   output logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   output logic [11:0] csr_addr,
   output logic        csr_read,
   output logic        csr_write,
   output logic [1:0]  csr_write_type,
   output logic [31:0] csr_bus,
   output logic [31:0] csr_tval,
   output logic        trap,
   output logic [4:0]  trap_cause,
   output logic        ret,
   output logic        redirect,
   output logic [31:0] new_pc
);

   typedef enum logic [2:0] {IDLE, DECODE, READ, WRITE, TRAP, RET, DONE} state_t;

   state_t      state, state_nx;
   logic [31:0] instr_q, pc_q, rs1_q, tval_q, rdata_q;
   logic [4:0]  cause_q, cause_nx;
   logic        set_cause, latch_rdata;

   logic [2:0]  funct3;
   logic [11:0] csr_a;
   logic [31:0] operand;
   logic        wr_req;
   state_t      dec_state;
   logic [4:0]  dec_cause;

   assign funct3  = instr_q[14:12];
   assign csr_a   = instr_q[31:20];
   assign operand = funct3[2] ? {27'd0, instr_q[19:15]} : rs1_q;
   // CSRRW/CSRRWI always write; set/clear forms write only with a nonzero rs1/uimm field.
   assign wr_req  = (funct3[1:0] == 2'b01) || (instr_q[19:15] != 5'd0);

   always_comb begin
      dec_state = TRAP;
      dec_cause = 5'd2;
      if (instr_q[6:0] == 7'b1110011) begin
         case (funct3)
            3'b001, 3'b010, 3'b011, 3'b101, 3'b110, 3'b111: dec_state = READ;
            3'b000: begin
               if (csr_a == 12'h000)      dec_cause = 5'd11;
               else if (csr_a == 12'h001) dec_cause = 5'd3;
               else if (csr_a == 12'h302) dec_state = RET;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      set_cause      = 1'b0;
      cause_nx       = 5'd2;
      latch_rdata    = 1'b0;
      busy           = (state != IDLE);
      done           = 1'b0;
      rd_we          = 1'b0;
      rd_addr        = 5'd0;
      rd_data        = 32'd0;
      csr_addr       = 12'd0;
      csr_read       = 1'b0;
      csr_write      = 1'b0;
      csr_write_type = 2'b00;
      csr_bus        = 32'd0;
      csr_tval       = 32'd0;
      trap           = 1'b0;
      trap_cause     = 5'd0;
      ret            = 1'b0;
      redirect       = 1'b0;
      new_pc         = 32'd0;
      case (state)
         IDLE: begin
            if (exc_req)    state_nx = TRAP;
            else if (start) state_nx = DECODE;
         end
         DECODE: begin
            state_nx = dec_state;
            if (dec_state == TRAP) begin
               set_cause = 1'b1;
               cause_nx  = dec_cause;
            end
         end
         READ: begin
            csr_read = 1'b1;
            csr_addr = csr_a;
            // Address space 0xC00-0xFFF is read-only; writing it is illegal.
            if (csr_invalid || (wr_req && csr_a[11:10] == 2'b11)) begin
               state_nx  = TRAP;
               set_cause = 1'b1;
            end else begin
               latch_rdata = 1'b1;
               state_nx    = wr_req ? WRITE : DONE;
            end
         end
         WRITE: begin
            csr_write      = 1'b1;
            csr_write_type = funct3[1:0];
            csr_bus        = operand;
            csr_addr       = csr_a;
            state_nx       = DONE;
         end
         TRAP: begin
            trap       = 1'b1;
            trap_cause = cause_q;
            csr_bus    = pc_q;
            csr_tval   = tval_q;
            redirect   = 1'b1;
            new_pc     = MTVEC_ADDR;
            state_nx   = IDLE;
         end
         RET: begin
            ret      = 1'b1;
            csr_read = 1'b1;
            csr_addr = 12'h341;
            redirect = 1'b1;
            new_pc   = {csr_rdata[31:2], 2'b00};
            state_nx = IDLE;
         end
         DONE: begin
            done     = 1'b1;
            rd_addr  = instr_q[11:7];
            rd_we    = (instr_q[11:7] != 5'd0);
            rd_data  = rdata_q;
            redirect = 1'b1;
            new_pc   = pc_q + 32'd4;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         instr_q <= 32'd0;
         pc_q    <= 32'd0;
         rs1_q   <= 32'd0;
         tval_q  <= 32'd0;
         rdata_q <= 32'd0;
         cause_q <= 5'd0;
      end else begin
         if (state == IDLE) begin
            if (exc_req) begin
               cause_q <= exc_cause;
               tval_q  <= exc_addr;
               pc_q    <= pc;
            end else if (start) begin
               instr_q <= instr;
               pc_q    <= pc;
               rs1_q   <= rs1_val;
               tval_q  <= pc;
            end
         end
         if (set_cause)   cause_q <= cause_nx;
         if (latch_rdata) rdata_q <= csr_rdata;
      end
   end

endmodule

// File: tb/tb_csr_sequencer.sv
// Randomized bench for csr_sequencer: an event-level model predicts on which cycle each
// strobe fires and what data accompanies it, and every cycle of each operation is compared.
module tb_csr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] instr, pc, rs1_val, exc_addr, csr_rdata;
   logic        exc_req, csr_invalid;
   logic [4:0]  exc_cause;
   logic        busy, done, rd_we, csr_read, csr_write, trap, ret, redirect;
   logic [4:0]  rd_addr, trap_cause;
   logic [31:0] rd_data, csr_bus, csr_tval, new_pc;
   logic [11:0] csr_addr;
   logic [1:0]  csr_write_type;

   int n_chk = 0;
   int n_fail = 0;

   csr_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr), .pc(pc), .rs1_val(rs1_val),
      .exc_req(exc_req), .exc_cause(exc_cause), .exc_addr(exc_addr),
      .csr_rdata(csr_rdata), .csr_invalid(csr_invalid),
      .busy(busy), .done(done), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
      .csr_addr(csr_addr), .csr_read(csr_read), .csr_write(csr_write),
      .csr_write_type(csr_write_type), .csr_bus(csr_bus), .csr_tval(csr_tval),
      .trap(trap), .trap_cause(trap_cause), .ret(ret), .redirect(redirect), .new_pc(new_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mk(input logic [11:0] c, input logic [4:0] r1,
                                      input logic [2:0] f3, input logic [4:0] rd);
      return {c, r1, f3, rd, 7'b1110011};
   endfunction

   function automatic logic [7:0] strobes();
      return {busy, csr_read, csr_write, trap, ret, redirect, done, rd_we};
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; exc_req = 1'b0; instr = '0; pc = '0; rs1_val = '0;
      exc_cause = '0; exc_addr = '0; csr_rdata = '0; csr_invalid = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if ({strobes(), rd_addr, rd_data, csr_addr, csr_write_type, csr_bus, csr_tval, trap_cause, new_pc} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs strobes=%b rd_data=%h csr_bus=%h csr_tval=%h new_pc=%h expected all 0",
                  strobes(), rd_data, csr_bus, csr_tval, new_pc);
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({strobes(), rd_data, csr_bus, csr_tval, new_pc} !== '0) begin
         n_fail++;
         $display("FAIL idle_after_reset strobes=%b new_pc=%h expected all 0", strobes(), new_pc);
      end
   endtask

   // Drives one operation starting at cycle 0 and compares cycles 1..end+1 against the model.
   task automatic run_op(input logic [31:0] i_instr, input logic [31:0] i_pc, input logic [31:0] i_rs1,
                         input logic [31:0] i_rdata, input logic i_inv, input logic i_exc,
                         input logic [4:0] i_cause, input logic [31:0] i_eaddr, input logic noisy,
                         input string name);
      logic [31:0] ins = i_instr;
      logic [31:0] rdv = i_rdata;
      logic [2:0]  f3 = ins[14:12];
      logic [4:0]  r1f = ins[19:15];
      logic [4:0]  rdf = ins[11:7];
      logic [11:0] csr = ins[31:20];
      logic [31:0] oper;
      logic [31:0] tval;
      logic [4:0]  ecause = 5'd2;
      logic [7:0]  m;
      logic        wr;
      int rd_c = 0, wr_c = 0, end_c = 2, kind = 1;   // kind: 0 done, 1 trap, 2 ret

      oper = f3[2] ? {27'd0, r1f} : i_rs1;
      tval = i_exc ? i_eaddr : i_pc;
      if (i_exc) begin
         end_c = 1; ecause = i_cause;
      end else if (ins[6:0] != 7'b1110011 || f3 == 3'd4) begin
         end_c = 2;
      end else if (f3 == 3'd0) begin
         if (csr == 12'h000) ecause = 5'd11;
         else if (csr == 12'h001) ecause = 5'd3;
         else if (csr == 12'h302) kind = 2;
      end else begin
         wr = (f3[1:0] == 2'b01) || (r1f != 0);
         rd_c = 2;
         if (i_inv || (wr && csr[11:10] == 2'b11)) end_c = 3;
         else if (wr) begin wr_c = 3; end_c = 4; kind = 0; end
         else begin end_c = 3; kind = 0; end
      end

      @(negedge clk);
      start = 1'b1; exc_req = i_exc; instr = i_instr; pc = i_pc; rs1_val = i_rs1;
      exc_cause = i_cause; exc_addr = i_eaddr; csr_rdata = i_rdata; csr_invalid = i_inv;
      for (int c = 1; c <= end_c + 1; c++) begin
         @(negedge clk);
         m = '0;
         if (c <= end_c) m[7] = 1'b1;
         if (c == rd_c)  m[6] = 1'b1;
         if (c == wr_c)  m[5] = 1'b1;
         if (c == end_c) begin
            m[2] = 1'b1;
            if (kind == 0) begin m[1] = 1'b1; m[0] = (rdf != 0); end
            else if (kind == 1) m[4] = 1'b1;
            else begin m[3] = 1'b1; m[6] = 1'b1; end
         end
         n_chk++;
         if (strobes() !== m) begin
            n_fail++;
            $display("FAIL %s strobes cycle %0d: got %b expected %b (busy,rd,wr,trap,ret,redir,done,we)",
                     name, c, strobes(), m);
         end
         if (c == rd_c) begin
            n_chk++;
            if (csr_addr !== csr) begin
               n_fail++;
               $display("FAIL %s read_addr: got %h expected %h", name, csr_addr, csr);
            end
         end
         if (c == wr_c) begin
            n_chk++;
            if ({csr_write_type, csr_bus, csr_addr} !== {f3[1:0], oper, csr}) begin
               n_fail++;
               $display("FAIL %s write: got type=%b bus=%h addr=%h expected type=%b bus=%h addr=%h",
                        name, csr_write_type, csr_bus, csr_addr, f3[1:0], oper, csr);
            end
         end
         if (c == end_c) begin
            n_chk++;
            if (kind == 0 && {rd_addr, rd_data, new_pc} !== {rdf, i_rdata, i_pc + 32'd4}) begin
               n_fail++;
               $display("FAIL %s done: got rd=%0d data=%h pc=%h expected rd=%0d data=%h pc=%h",
                        name, rd_addr, rd_data, new_pc, rdf, i_rdata, i_pc + 32'd4);
            end else if (kind == 1 && {trap_cause, csr_bus, csr_tval, new_pc} !== {ecause, i_pc, tval, 32'h4}) begin
               n_fail++;
               $display("FAIL %s trap: got cause=%0d bus=%h tval=%h pc=%h expected cause=%0d bus=%h tval=%h pc=4",
                        name, trap_cause, csr_bus, csr_tval, new_pc, ecause, i_pc, tval);
            end else if (kind == 2 && {csr_addr, new_pc} !== {12'h341, rdv[31:2], 2'b00}) begin
               n_fail++;
               $display("FAIL %s ret: got addr=%h pc=%h expected addr=341 pc=%h",
                        name, csr_addr, new_pc, {rdv[31:2], 2'b00});
            end
         end
         // Busy-time noise on start/exc_req/operands must be ignored by the DUT.
         if (noisy && c < end_c) begin
            start = 1'($urandom_range(0, 1)); exc_req = 1'($urandom_range(0, 1));
            instr = $urandom; pc = $urandom; rs1_val = $urandom;
            exc_cause = 5'($urandom); exc_addr = $urandom;
         end else begin
            start = 1'b0; exc_req = 1'b0;
         end
      end
   endtask

   task automatic test_directed();
      run_op(mk(12'h340, 5'd5, 3'b001, 5'd3), 32'h100, 32'hDEADBEEF, 32'h12, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "csrrw");
      run_op(mk(12'hF14, 5'd0, 3'b010, 5'd7), 32'h180, 32'h55, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "csrrs_x0");
      run_op(mk(12'hF11, 5'd3, 3'b101, 5'd4), 32'h1C0, 32'h0, 32'h9, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "csrrwi_ro");
      run_op(mk(12'h000, 5'd0, 3'b000, 5'd0), 32'h200, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "ecall");
      run_op(mk(12'h001, 5'd0, 3'b000, 5'd0), 32'h204, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "ebreak");
      run_op(mk(12'h302, 5'd0, 3'b000, 5'd0), 32'h300, 32'h0, 32'h203, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "mret");
      run_op(mk(12'h340, 5'd5, 3'b100, 5'd3), 32'h310, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "funct3_100");
      run_op(mk(12'h305, 5'd2, 3'b011, 5'd0), 32'h320, 32'hF0, 32'h77, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, "csr_invalid");
      run_op(mk(12'h340, 5'd5, 3'b111, 5'd9), 32'hFFFFFFFC, 32'h0, 32'hA5, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "pc_wrap");
      run_op(mk(12'h340, 5'd0, 3'b001, 5'd3), 32'h400, 32'h0, 32'h3, 1'b0, 1'b1, 5'd4, 32'h1001, 1'b0, "exc_with_start");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      start = 1'b1; instr = mk(12'h340, 5'd5, 3'b001, 5'd3); pc = 32'h100; rs1_val = 32'h1234;
      csr_rdata = 32'h12; csr_invalid = 1'b0;
      @(negedge clk); start = 1'b0;
      repeat (2) @(negedge clk);
      n_chk++;
      if (csr_write !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_mid_write: csr_write=%b expected 1", csr_write);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_chk++;
      if ({strobes(), rd_addr, rd_data, csr_addr, csr_write_type, csr_bus, csr_tval, trap_cause, new_pc} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_idle strobes=%b csr_bus=%h new_pc=%h expected all 0", strobes(), csr_bus, new_pc);
      end
      run_op(mk(12'h340, 5'd6, 3'b010, 5'd1), 32'h500, 32'h8, 32'h44, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, "after_reset");
   endtask

   task automatic test_random();
      logic [11:0] csrs [6];
      logic [11:0] sys [4];
      logic [11:0] c;
      logic [2:0]  f3;
      logic [4:0]  r1;
      logic [31:0] ins;
      csrs = '{12'hF14, 12'hF11, 12'h340, 12'h300, 12'hC00, 12'h000};
      sys  = '{12'h000, 12'h001, 12'h302, 12'h000};
      for (int k = 0; k < 60; k++) begin
         f3 = 3'($urandom_range(0, 7));
         c  = csrs[$urandom_range(0, 5)];
         if (c == 12'h000) c = 12'($urandom);
         if (f3 == 3'd0) begin
            c = sys[$urandom_range(0, 3)];
            if ($urandom_range(0, 3) == 0) c = 12'($urandom);
         end
         r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         ins = mk(c, r1, f3, 5'($urandom));
         if ($urandom_range(0, 7) == 0) ins[6:0] = 7'($urandom);
         run_op(ins, $urandom, $urandom, $urandom, ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 7) == 0), 5'($urandom), $urandom,
                1'($urandom_range(0, 1)), "random");
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
